// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control path: FSM states, instruction
// classes, ALU operation codes, opcodes and datapath select encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_OP      = 3'd0,
    CLS_OP_IMM  = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_LUI     = 3'd5,
    CLS_JAL     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_t;

  // ALU operation codes, shared with the ALU.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] F3_WORD = 3'b010;

  // Maps an OP/OP-IMM funct3 to the ALU operation, ignoring SUB selection.
  function automatic logic [3:0] alu_op_from_funct3(input logic [2:0] funct3);
    case (funct3)
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies the IR contents and yields the
// ALU operation, immediate format and an illegal-instruction flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic [31:0]  instr,
  output instr_class_t cls,
  output logic [3:0]   alu_op,
  output logic [2:0]   imm_sel,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op;
  logic       is_shift;
  logic       alu_legal;
  logic       unused_fields;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign is_op    = (opcode == OPC_OP);
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // rd and the register specifiers are consumed by the datapath, not here.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Register ops accept funct7 = 0 (or SUB); immediate ops only constrain shifts.
  always_comb begin
    alu_legal = 1'b0;
    if (funct3 != 3'b011) begin
      if (funct7 == 7'h00)
        alu_legal = 1'b1;
      else if (is_op)
        alu_legal = (funct3 == 3'b000) && (funct7 == 7'h20);
      else
        alu_legal = !is_shift;
    end
  end

  always_comb begin
    cls     = CLS_ILLEGAL;
    alu_op  = ALU_ADD;
    imm_sel = IMM_I;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        alu_op = (is_op && funct7[5] && funct3 == 3'b000) ? ALU_SUB
                                                          : alu_op_from_funct3(funct3);
        if (alu_legal)
          cls = is_op ? CLS_OP : CLS_OP_IMM;
      end
      OPC_LOAD: begin
        if (funct3 == F3_WORD)
          cls = CLS_LOAD;
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        if (funct3 == F3_WORD)
          cls = CLS_STORE;
      end
      OPC_BRANCH: begin
        alu_op  = ALU_SUB;
        imm_sel = IMM_B;
        if (funct3[2:1] == 2'b00)
          cls = CLS_BRANCH;
      end
      OPC_LUI: begin
        imm_sel = IMM_U;
        cls     = CLS_LUI;
      end
      OPC_JAL: begin
        imm_sel = IMM_J;
        if (SUPPORT_JAL)
          cls = CLS_JAL;
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath enables and selects combinationally from state and IR.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit SUPPORT_JAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic [3:0]  alu_op,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [2:0]  imm_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_src,
  output logic        retire,
  output logic        illegal
);

  state_t       state_q;
  state_t       state_d;
  instr_class_t cls;
  logic [3:0]   dec_alu_op;
  logic [2:0]   dec_imm_sel;
  logic         dec_illegal;
  logic         rd_nonzero;

  ctrl_decode #(
    .SUPPORT_JAL(SUPPORT_JAL)
  ) u_decode (
    .instr   (instr),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .imm_sel (dec_imm_sel),
    .illegal (dec_illegal)
  );

  assign rd_nonzero = |instr[11:7];

  // NOTE: state uses non-blocking assignment; reset is asynchronous so the
  // outputs, being decoded from state, fall to 0 within the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= S_START;
    else
      state_q <= state_d;
  end

  // NOTE: every output and the next state get a default first, so no branch
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    alu_op    = ALU_ADD;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    imm_sel   = IMM_I;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_START: state_d = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: state_d = dec_illegal ? S_TRAP : S_EXEC;

      S_EXEC: begin
        case (cls)
          CLS_OP, CLS_OP_IMM: begin
            alu_op    = dec_alu_op;
            alu_b_sel = (cls == CLS_OP_IMM);
            imm_sel   = dec_imm_sel;
            state_d   = S_WB;
          end
          CLS_LUI: begin
            alu_op    = ALU_ADD;
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
            imm_sel   = IMM_U;
            state_d   = S_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op    = ALU_ADD;
            alu_b_sel = 1'b1;
            imm_sel   = dec_imm_sel;
            state_d   = S_MEM;
          end
          CLS_BRANCH: begin
            // funct3[0] distinguishes BNE from BEQ and inverts the zero test.
            alu_op  = ALU_SUB;
            imm_sel = IMM_B;
            pc_src  = alu_zero ^ instr[12];
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_JAL: state_d = S_WB;
          default: state_d = S_TRAP;
        endcase
      end

      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we = rd_nonzero;
        if (cls == CLS_LOAD)
          wb_sel = WB_MEM;
        else if (cls == CLS_JAL)
          wb_sel = WB_PC4;
        pc_we   = 1'b1;
        pc_src  = (cls == CLS_JAL);
        imm_sel = (cls == CLS_JAL) ? IMM_J : IMM_I;
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: illegal = 1'b1;

      default: state_d = S_START;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I-subset core. It sequences fetch, decode, execute, memory and writeback, decodes the instruction register into the 4-bit ALU operation code, and drives datapath enables and selects. It is the initiator side of the ALU: it generates `alu_op` and consumes `alu_zero`. It sits between the instruction/data memory handshake and the datapath (register file, ALU, PC, IR).

## Interface
- `SUPPORT_JAL`, default 1: when 0, JAL decodes as illegal.
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `instr`  in  32  IR contents, held by datapath
- `alu_zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes current request this cycle
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = store
- `addr_sel`  out  1  0 = PC, 1 = ALUOut
- `ir_we`  out  1  load IR from memory rdata
- `alu_op`  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL
- `alu_a_sel`  out  1  0 = rs1, 1 = zero
- `alu_b_sel`  out  1  0 = rs2, 1 = immediate
- `imm_sel`  out  3  0 I, 1 S, 2 B, 3 U, 4 J
- `rf_we`  out  1  register write
- `wb_sel`  out  2  00 ALUOut, 01 mem rdata, 10 PC+4
- `pc_we`  out  1  PC update
- `pc_src`  out  1  0 = PC+4, 1 = PC+imm
- `retire`  out  1  one-cycle pulse per completed instruction
- `illegal`  out  1  sticky trap flag

## Operation
- States: START, FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are combinational from state and the registered `instr`. In any output/state not listed below, every output is 0.
- START: all outputs 0. Goes to FETCH.
- FETCH: `mem_req`=1, `addr_sel`=0. On `mem_ready`, `ir_we`=1 and the FSM goes to DECODE; otherwise it stays in FETCH.
- DECODE: illegal instruction → TRAP; otherwise → EXEC.
- Supported instructions:
  - OP (0110011) and OP-IMM (0010011):
    - funct3 000: ADD; SUB when OP and funct7[5]=1.
    - funct3 001: SLL.
    - funct3 010: SLT.
    - funct3 100: XOR.
    - funct3 101: SRL; funct7[5]=1 (SRA/SRAI) is illegal.
    - funct3 110: OR.
    - funct3 111: AND.
    - funct3 011 (SLTU) is illegal.
    - OP-IMM with funct3 001/101 requires funct7=0.
  - LOAD: LW only.
  - STORE: SW only.
  - BRANCH: BEQ and BNE only.
  - LUI.
  - JAL, when `SUPPORT_JAL`=1.
  - All other encodings are illegal.
- EXEC:
  - ALU/LUI → WB. LUI: `alu_a_sel`=1, `alu_b_sel`=1, `imm_sel`=U, ADD.
  - LW/SW → MEM, with ADD and `imm_sel` I/S.
  - BEQ/BNE: SUB on rs1/rs2. `pc_src` = `alu_zero` XOR funct3[0]. `pc_we`=1, `retire`=1, then → FETCH.
  - JAL → WB.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=1 for SW.
  - On `mem_ready`, SW: `pc_we`=1, `pc_src`=0, `retire`=1, then → FETCH.
  - On `mem_ready`, LW: → WB.
- WB: `rf_we`=1 unless rd=0. `wb_sel` is 00 (ALU/LUI), 01 (LW) or 10 (JAL). `pc_we`=1. `pc_src`=1 for JAL (`imm_sel`=J), else 0. `retire`=1. Then → FETCH.
- TRAP: `illegal`=1, all other outputs 0. Exits only on reset.

## Timing
- Reset: the state is forced to START asynchronously, so all outputs are 0 in the same cycle, including mid-transaction. The memory side must tolerate an abandoned request.
- Cycles per instruction, with `mem_ready` high on the first request cycle:
  - ALU, LUI, JAL: 4.
  - Branch: 3.
  - SW: 4.
  - LW: 5.
  - Each wait cycle on a memory handshake adds 1.
- `mem_req` stays high continuously until the `mem_ready` cycle. `mem_ready` is ignored when `mem_req`=0.
- `retire` pulses exactly once per instruction, in its final cycle. It never pulses for an illegal instruction.
- After a TRAP, the first `mem_req` following deassertion of `reset` is 2 cycles later (START, then FETCH).

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - the `alu_op` localparams, shared with the ALU;
  - the opcode constants;
  - the `imm_sel` and `wb_sel` encodings.
- Sub-module `ctrl_decode`: combinational. Maps `instr` and `SUPPORT_JAL` to an instruction class, `alu_op`, `imm_sel` and `illegal`.
- `multicycle_ctrl` holds the state register and the output decode.

## Test plan
- Reset, then `instr`=0x002081B3 (ADD x3,x1,x2) with `mem_ready`=1:
  - states START, FETCH, DECODE, EXEC, WB;
  - in EXEC, `alu_op`=0000 with both selects 0;
  - in WB, `rf_we`=1, `wb_sel`=00, `pc_we`=1 and `retire`=1.
- Decode checks:
  - 0x402081B3 → `alu_op` 0001.
  - 0x0020D1B3 → 0111.
  - 0x0020B1B3 (SLTU) → TRAP with `illegal`=1 and no further `mem_req`; reset returns to START.
- 0x0000A183 (LW) with `mem_ready` low for 3 MEM cycles:
  - `mem_req` and `addr_sel`=1 held 4 cycles;
  - then WB with `wb_sel`=01.
- 0x00208463 (BEQ):
  - `alu_zero`=1 → EXEC has `alu_op`=0001, `pc_src`=1, `pc_we`=1, then FETCH.
  - 0x00209463 (BNE) with `alu_zero`=1 → `pc_src`=0.
- SW (0x0020A023): assert `reset` mid-MEM → `mem_req` and `mem_we` drop to 0 in the same cycle, and the FSM restarts at START.
- `SUPPORT_JAL`=0 with JAL 0x008000EF → TRAP. With `SUPPORT_JAL`=1 → WB with `wb_sel`=10 and `pc_src`=1.
